// File: rtl/rename_free_list_pkg.sv
// Shared types and defaults for the physical-register free list.
// Widths here match the default 64/32 physical/architectural split.
package rename_free_list_pkg;

    localparam int PHYS_REGS_DEF = 64;
    localparam int ARCH_REGS_DEF = 32;
    localparam int PREG_W_DEF    = $clog2(PHYS_REGS_DEF);
    localparam int DEPTH_DEF     = PHYS_REGS_DEF - ARCH_REGS_DEF;
    localparam int IDX_W_DEF     = $clog2(DEPTH_DEF);

    typedef logic [PREG_W_DEF-1:0] preg_t;

    typedef struct packed {
        logic                 wrap;
        logic [IDX_W_DEF-1:0] idx;
    } free_list_ptr_t;

endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical register IDs with a speculative head
// for rename and a commit head that a flush rolls the speculative head back to.
module rename_free_list
    import rename_free_list_pkg::*;
#(
    parameter int PHYS_REGS = PHYS_REGS_DEF,
    parameter int ARCH_REGS = ARCH_REGS_DEF,
    parameter int PREG_W    = $clog2(PHYS_REGS),
    parameter int DEPTH     = PHYS_REGS - ARCH_REGS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       deq_req,
    output logic                       deq_valid,
    output logic [PREG_W-1:0]          deq_preg,
    input  logic                       enq_valid,
    input  logic [PREG_W-1:0]          enq_preg,
    input  logic                       commit_alloc,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] free_count,
    output logic                       overflow_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             wrap;
        logic [IDX_W-1:0] idx;
    } ptr_t;

    logic [PREG_W-1:0] mem [DEPTH];
    ptr_t spec_head;
    ptr_t commit_head;
    ptr_t tail;

    ptr_t              commit_head_next;
    logic [PTR_W-1:0]  count_spec;
    logic [PTR_W-1:0]  count_commit;
    logic              deq_fire;
    logic              enq_full;
    logic              enq_fire;

    // Advance a pointer, flipping the wrap bit when the index rolls over.
    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t r;
        if (p.idx == IDX_W'(DEPTH - 1)) begin
            r.wrap = ~p.wrap;
            r.idx  = '0;
        end else begin
            r.wrap = p.wrap;
            r.idx  = p.idx + 1'b1;
        end
        return r;
    endfunction

    // Entries between head b and tail a; equal wrap bits mean same lap.
    function automatic logic [PTR_W-1:0] ptr_diff(input ptr_t a, input ptr_t b);
        if (a.wrap == b.wrap)
            return PTR_W'(a.idx) - PTR_W'(b.idx);
        else
            return PTR_W'(DEPTH) - PTR_W'(b.idx) + PTR_W'(a.idx);
    endfunction

    // Occupancy, handshake qualification and next commit head.
    always_comb begin
        count_spec       = ptr_diff(tail, spec_head);
        count_commit     = ptr_diff(tail, commit_head);
        deq_valid        = (count_spec != '0);
        deq_preg         = mem[spec_head.idx];
        free_count       = CNT_W'(count_spec);
        deq_fire         = deq_req && deq_valid && !flush;
        enq_full         = (count_commit == PTR_W'(DEPTH));
        enq_fire         = enq_valid && !enq_full;
        commit_head_next = commit_alloc ? ptr_inc(commit_head) : commit_head;
    end

    // Pointer, storage and sticky overflow update; reset restores full list.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= PREG_W'(ARCH_REGS + i);
            spec_head    <= '0;
            commit_head  <= '0;
            tail         <= '{wrap: 1'b1, idx: '0};
            overflow_err <= 1'b0;
        end else begin
            if (enq_fire) begin
                mem[tail.idx] <= enq_preg;
                tail          <= ptr_inc(tail);
            end
            if (enq_valid && enq_full)
                overflow_err <= 1'b1;
            commit_head <= commit_head_next;
            if (flush)
                spec_head <= commit_head_next;
            else if (deq_fire)
                spec_head <= ptr_inc(spec_head);
        end
    end

    // Commit may never retire an allocation rename has not yet made.
    assert property (@(posedge clk) disable iff (rst)
        !(commit_alloc && commit_head == spec_head));

endmodule

// File: tb/tb_rename_free_list.sv
// Directed test of the free list with hand-computed expected values.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_rename_free_list;

    logic       clk;
    logic       rst;
    logic       deq_req;
    logic       deq_valid;
    logic [5:0] deq_preg;
    logic       enq_valid;
    logic [5:0] enq_preg;
    logic       commit_alloc;
    logic       flush;
    logic [5:0] free_count;
    logic       overflow_err;

    int checks;
    int errors;

    rename_free_list dut (
        .clk          (clk),
        .rst          (rst),
        .deq_req      (deq_req),
        .deq_valid    (deq_valid),
        .deq_preg     (deq_preg),
        .enq_valid    (enq_valid),
        .enq_preg     (enq_preg),
        .commit_alloc (commit_alloc),
        .flush        (flush),
        .free_count   (free_count),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        deq_req      = 1'b0;
        enq_valid    = 1'b0;
        enq_preg     = '0;
        commit_alloc = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic deq_n(input int n);
        for (int i = 0; i < n; i++) begin
            deq_req = 1'b1;
            tick();
        end
        deq_req = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        #12;
        check("rst_deq_valid", deq_valid, 1);
        check("rst_deq_preg", deq_preg, 32);
        check("rst_free_count", free_count, 32);
        check("rst_overflow", overflow_err, 0);
        rst = 1'b0;
        tick();

        enq_valid = 1'b1;
        enq_preg  = 6'd7;
        tick();
        idle();
        check("ovf_set", overflow_err, 1);
        check("ovf_count", free_count, 32);
        check("ovf_head", deq_preg, 32);

        for (int i = 0; i < 32; i++) begin
            deq_req = 1'b1;
            check("b2b_valid", deq_valid, 1);
            check("b2b_preg", deq_preg, 32 + i);
            tick();
        end
        deq_req = 1'b0;
        check("empty_valid", deq_valid, 0);
        check("empty_count", free_count, 0);
        deq_req = 1'b1;
        tick();
        deq_req = 1'b0;
        check("deq33_count", free_count, 0);
        check("deq33_valid", deq_valid, 0);

        commit_alloc = 1'b1;
        tick();
        commit_alloc = 1'b0;
        deq_req   = 1'b1;
        enq_valid = 1'b1;
        enq_preg  = 6'd9;
        check("nobypass_valid", deq_valid, 0);
        tick();
        idle();
        check("enq_empty_valid", deq_valid, 1);
        check("enq_empty_preg", deq_preg, 9);
        check("enq_empty_count", free_count, 1);
        check("ovf_sticky", overflow_err, 1);

        deq_req   = 1'b1;
        enq_valid = 1'b1;
        enq_preg  = 6'd11;
        rst       = 1'b1;
        #2;
        check("arst_count", free_count, 32);
        check("arst_preg", deq_preg, 32);
        check("arst_ovf", overflow_err, 0);
        rst = 1'b0;
        idle();
        tick();

        deq_n(3);
        check("d3_count", free_count, 29);
        commit_alloc = 1'b1;
        tick();
        commit_alloc = 1'b0;
        enq_valid = 1'b1;
        enq_preg  = 6'd5;
        tick();
        idle();
        check("enq5_count", free_count, 30);
        check("enq5_ovf", overflow_err, 0);
        deq_n(29);
        check("wrap_preg", deq_preg, 5);
        check("wrap_count", free_count, 1);
        pulse_rst();

        deq_n(4);
        check("d4_preg", deq_preg, 36);
        commit_alloc = 1'b1;
        tick();
        tick();
        commit_alloc = 1'b0;
        flush = 1'b1;
        tick();
        idle();
        check("flush_preg", deq_preg, 34);
        check("flush_count", free_count, 30);
        pulse_rst();

        deq_n(5);
        commit_alloc = 1'b1;
        tick();
        commit_alloc = 1'b0;
        check("pre_flush_preg", deq_preg, 37);
        deq_req      = 1'b1;
        commit_alloc = 1'b1;
        flush        = 1'b1;
        tick();
        idle();
        check("fdc_preg", deq_preg, 34);
        check("fdc_count", free_count, 30);
        check("fdc_valid", deq_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rename_free_list.md
Name: rename_free_list

Overview:
- Parametrised physical-register free list for the out-of-order core. Generalises the fixed 8-bit free_list_t to arbitrary physical/architectural register counts.
- Circular buffer of free physical register IDs:
  - Rename dequeues one ID per allocating instruction.
  - ROB commit enqueues the superseded old mapping.
- Keeps a separate commit-side head pointer. A pipeline flush restores speculative allocations in one cycle.

Parameters:
- PHYS_REGS, 64, total physical registers; power of two, ≥ ARCH_REGS+2.
- ARCH_REGS, 32, architectural registers; p0..p(ARCH_REGS-1) are mapped at reset and never appear in the list initially.
- PREG_W, $clog2(PHYS_REGS), physical register ID width.
- DEPTH, PHYS_REGS-ARCH_REGS, list capacity; derived, must not be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- deq_req  in  1  rename requests one free register this cycle.
- deq_valid  out  1  list non-empty; deq_preg is usable.
- deq_preg  out  PREG_W  ID at the speculative head (combinational from state).
- enq_valid  in  1  commit frees a physical register.
- enq_preg  in  PREG_W  ID being freed.
- commit_alloc  in  1  committing instruction had allocated a register; advances the commit head.
- flush  in  1  squash all speculative allocations.
- free_count  out  $clog2(DEPTH+1)  number of speculatively free entries.
- overflow_err  out  1  sticky; enqueue attempted while full.

Behaviour:
- State:
  - mem[DEPTH] of PREG_W.
  - spec_head, commit_head, tail: each $clog2(DEPTH)+1 bits, with the MSB as the wrap bit.
- Reset (async, rst=1):
  - mem[i] = ARCH_REGS+i.
  - spec_head = commit_head = 0.
  - tail = DEPTH with wrap bit set, i.e. the list is full.
  - Outputs during reset: deq_valid=1, deq_preg=ARCH_REGS, free_count=DEPTH, overflow_err=0.
- Count: free_count = tail - spec_head (pointer subtraction, full width). deq_valid = (free_count != 0).
- Dequeue fires when deq_req && deq_valid && !flush:
  - spec_head increments next edge.
  - deq_preg is valid in the same cycle it is requested; zero-cycle latency.
- deq_req while empty: ignored, no pointer change. Rename must stall on !deq_valid.
- Enqueue fires when enq_valid && count_commit != DEPTH, where count_commit = tail - commit_head:
  - mem[tail] <= enq_preg; tail increments.
  - If full: write dropped, overflow_err <= 1 (sticky until rst).
- enq_preg == 0: treated as a normal ID. Commit logic must never free p0.
- commit_alloc: commit_head increments. It must not pass spec_head; violation is a simulation assertion only.
- Flush:
  - spec_head <= commit_head_next, which includes any commit_alloc in the same cycle.
  - A dequeue in the flush cycle is discarded.
  - enq and commit_alloc in the flush cycle still take effect.
- Simultaneous deq + enq, no flush:
  - Both apply; free_count unchanged.
  - No bypass: on an empty list, deq_valid stays 0 that cycle and the enqueued ID is visible next cycle.
- Wrap-around: pointer index = low bits, compared together with the wrap bit. Full/empty are distinguished by the wrap bit.
- Reset mid-operation: all pointers and mem return to the reset image regardless of pending requests.

Decomposition:
- rv32i_types additions:
  - localparam PHYS_REGS/ARCH_REGS defaults.
  - typedef logic [PREG_W-1:0] preg_t, replacing free_list_t.
  - struct free_list_ptr_t {logic wrap; logic [idx-1:0] idx;}.
- No sub-module required; pointer increment/compare lives in local functions.

Test Plan:
- Reset, then 32 back-to-back deq_req (defaults) -> deq_preg = 32,33,…,63 on consecutive cycles; then deq_valid=0, free_count=0. A 33rd deq_req changes nothing.
- Dequeue 3 (p32–p34), enq_valid with enq_preg=5, commit_alloc=1 -> free_count 29→30. After a full wrap, p5 appears at index 0 of the second lap.
- Dequeue 4 (p32–p35), commit_alloc twice, flush -> spec_head = commit_head = 2, deq_preg=34, free_count=30.
- Flush asserted together with deq_req and commit_alloc, from commit_head=1, spec_head=5 -> spec_head=2, deq_preg=34, dequeue discarded.
- Full list (post-reset), enq_valid with enq_preg=7 -> mem unchanged, overflow_err=1 and held until rst.
- Empty list, simultaneous deq_req and enq_valid(enq_preg=9) -> no grant that cycle; next cycle deq_valid=1, deq_preg=9. Also: rst pulsed mid-stream -> reset image immediately, asynchronously.
